// File: rtl/softex_tcdm_splitter.sv
// Wide-to-narrow TCDM splitter: fans one MP-port request out to independent
// 64-bit ports, tracks per-port grants, and reassembles per-port read
// responses into one in-order wide response.

// Small registered FIFO used for per-port read data and for read IDs.
module softex_tcdm_splitter_fifo #(
  parameter int unsigned DW    = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic [DW-1:0] data_o,
  output logic          empty_o,
  output logic          full_o
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          push_ok, pop_ok;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_q];

  // Storage, pointers and occupancy; storage is cleared so heads never read X.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= inc(wr_q);
      end
      if (pop_ok) rd_q <= inc(rd_q);
      if (push_ok & ~pop_ok)      cnt_q <= cnt_q + CW'(1);
      else if (~push_ok & pop_ok) cnt_q <= cnt_q - CW'(1);
    end
  end
endmodule

module softex_tcdm_splitter #(
  parameter int unsigned MP      = 4,
  parameter int unsigned PORT_DW = 64,
  parameter int unsigned AW      = 32,
  parameter int unsigned IW      = 8,
  parameter int unsigned STRIDE  = 32,
  parameter int unsigned DEPTH   = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_req_i,
  output logic                  in_gnt_o,
  input  logic [AW-1:0]         in_add_i,
  input  logic                  in_wen_i,
  input  logic [MP*8-1:0]       in_be_i,
  input  logic [MP*PORT_DW-1:0] in_data_i,
  input  logic [IW-1:0]         in_id_i,
  output logic                  in_r_valid_o,
  input  logic                  in_r_ready_i,
  output logic [MP*PORT_DW-1:0] in_r_data_o,
  output logic [IW-1:0]         in_r_id_o,
  output logic [MP-1:0]         tcdm_req_o,
  input  logic [MP-1:0]         tcdm_gnt_i,
  output logic [MP*AW-1:0]      tcdm_add_o,
  output logic [MP-1:0]         tcdm_wen_o,
  output logic [MP*8-1:0]       tcdm_be_o,
  output logic [MP*PORT_DW-1:0] tcdm_data_o,
  input  logic [MP-1:0]         tcdm_r_valid_i,
  input  logic [MP*PORT_DW-1:0] tcdm_r_data_i,
  output logic [MP-1:0]         tcdm_r_ready_o
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [MP-1:0] granted_q, granted_d, all_g;
  logic [MP-1:0] full, empty;
  logic [CW-1:0] outst_q, outst_d;
  logic          can_issue, rd_acc, pop;
  logic          id_empty, id_full;

  // Writes never need a response slot, so only reads are credit-limited.
  assign can_issue = ~in_wen_i | (outst_q < DEPTH_C);

  // Ports already granted for this transaction drop their request.
  assign tcdm_req_o  = {MP{in_req_i & can_issue}} & ~granted_q;
  assign all_g       = granted_q | (tcdm_req_o & tcdm_gnt_i);
  assign in_gnt_o    = in_req_i & can_issue & (&all_g);
  assign granted_d   = in_gnt_o ? '0 : all_g;

  assign tcdm_wen_o  = {MP{in_wen_i}};
  assign tcdm_be_o   = in_be_i;
  assign tcdm_data_o = in_data_i;

  assign rd_acc         = in_gnt_o & in_wen_i;
  assign tcdm_r_ready_o = ~full;
  assign in_r_valid_o   = ~|empty;
  assign pop            = in_r_valid_o & in_r_ready_i;

  genvar ii;
  generate
    for (ii = 0; ii < MP; ii++) begin : g_port
      assign tcdm_add_o[ii*AW +: AW] = in_add_i + AW'(ii * STRIDE);

      softex_tcdm_splitter_fifo #(.DW(PORT_DW), .DEPTH(DEPTH)) u_rfifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (tcdm_r_valid_i[ii] & tcdm_r_ready_o[ii]),
        .data_i (tcdm_r_data_i[ii*PORT_DW +: PORT_DW]),
        .pop_i  (pop),
        .data_o (in_r_data_o[ii*PORT_DW +: PORT_DW]),
        .empty_o(empty[ii]),
        .full_o (full[ii])
      );
    end
  endgenerate

  softex_tcdm_splitter_fifo #(.DW(IW), .DEPTH(DEPTH)) u_idfifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (rd_acc),
    .data_i (in_id_i),
    .pop_i  (pop),
    .data_o (in_r_id_o),
    .empty_o(id_empty),
    .full_o (id_full)
  );

  // Outstanding reads: +1 on read accept, -1 on wide pop, unchanged if both.
  always_comb begin
    outst_d = outst_q;
    if (rd_acc & ~pop)      outst_d = outst_q + CW'(1);
    else if (~rd_acc & pop) outst_d = outst_q - CW'(1);
  end

  // Grant-tracking and credit state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      granted_q <= '0;
      outst_q   <= '0;
    end else begin
      granted_q <= granted_d;
      outst_q   <= outst_d;
    end
  end

  a_outst_max: assert property (@(posedge clk_i) disable iff (rst_i) outst_q <= DEPTH_C);
  a_id_room:   assert property (@(posedge clk_i) disable iff (rst_i) rd_acc |-> !id_full);
  a_id_avail:  assert property (@(posedge clk_i) disable iff (rst_i) pop |-> !id_empty);
endmodule

// File: tb/tb_softex_tcdm_splitter.sv
// Scoreboard bench for softex_tcdm_splitter: a port-level memory model answers
// reads, expected wide responses are queued at wide grant and compared on pop.
module tb_softex_tcdm_splitter;
  localparam int MP = 4, DW = 64, AW = 32, IW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_req, in_wen, in_r_ready;
  logic [AW-1:0]   in_add;
  logic [MP*8-1:0] in_be;
  logic [MP*DW-1:0] in_data;
  logic [IW-1:0]   in_id;
  logic            in_gnt, in_r_valid;
  logic [MP*DW-1:0] in_r_data;
  logic [IW-1:0]   in_r_id;
  logic [MP-1:0]   tcdm_req, tcdm_gnt, tcdm_wen, tcdm_r_valid, tcdm_r_ready;
  logic [MP*AW-1:0] tcdm_add;
  logic [MP*8-1:0] tcdm_be;
  logic [MP*DW-1:0] tcdm_data, tcdm_r_data;

  typedef struct packed { logic [IW-1:0] id; logic [MP*DW-1:0] data; } exp_t;
  exp_t        exp_q[$];
  logic [63:0] resp_q[MP][$];
  logic [MP-1:0] resp_en;
  int n_chk = 0, n_err = 0, hs_cnt = 0, pop_cnt = 0;

  always #5 clk = ~clk;

  softex_tcdm_splitter dut (
    .clk_i(clk), .rst_i(rst),
    .in_req_i(in_req), .in_gnt_o(in_gnt), .in_add_i(in_add), .in_wen_i(in_wen),
    .in_be_i(in_be), .in_data_i(in_data), .in_id_i(in_id),
    .in_r_valid_o(in_r_valid), .in_r_ready_i(in_r_ready),
    .in_r_data_o(in_r_data), .in_r_id_o(in_r_id),
    .tcdm_req_o(tcdm_req), .tcdm_gnt_i(tcdm_gnt), .tcdm_add_o(tcdm_add),
    .tcdm_wen_o(tcdm_wen), .tcdm_be_o(tcdm_be), .tcdm_data_o(tcdm_data),
    .tcdm_r_valid_i(tcdm_r_valid), .tcdm_r_data_i(tcdm_r_data),
    .tcdm_r_ready_o(tcdm_r_ready)
  );

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Memory contents seen by each port.
  function automatic logic [63:0] fdat(input logic [31:0] a);
    return {~a, 21'h0, a[15:5] + 11'h20};
  endfunction

  function automatic logic [MP*DW-1:0] wide_exp(input logic [31:0] a);
    logic [MP*DW-1:0] w;
    for (int p = 0; p < MP; p++) w[p*DW +: DW] = fdat(a + 32'(p * 32));
    return w;
  endfunction

  // Drive port responses from the model, then let combinational paths settle.
  task automatic settle();
    for (int p = 0; p < MP; p++) begin
      if (resp_en[p] && resp_q[p].size() > 0) begin
        tcdm_r_valid[p] = 1'b1;
        tcdm_r_data[p*DW +: DW] = resp_q[p][0];
      end else begin
        tcdm_r_valid[p] = 1'b0;
        tcdm_r_data[p*DW +: DW] = '0;
      end
    end
    #2;
  endtask

  // Record handshakes of this cycle, then advance past the clock edge.
  task automatic tick();
    exp_t e;
    if (!rst) begin
      for (int p = 0; p < MP; p++) begin
        if (tcdm_req[p] & tcdm_gnt[p]) begin
          hs_cnt++;
          if (tcdm_wen[p]) resp_q[p].push_back(fdat(tcdm_add[p*AW +: AW]));
        end
        if (tcdm_r_valid[p] & tcdm_r_ready[p]) void'(resp_q[p].pop_front());
      end
      if (in_gnt & in_wen) begin
        e.id = in_id;
        e.data = wide_exp(in_add);
        exp_q.push_back(e);
      end
      if (in_r_valid & in_r_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) chk("unexp_rsp", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("rsp_id", in_r_id, e.id);
          chk("rsp_data", in_r_data, e.data);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  task automatic issue(input logic wen, input logic [31:0] a, input logic [7:0] id);
    in_req = 1'b1; in_wen = wen; in_add = a; in_id = id;
  endtask

  task automatic drain(input string tag);
    int n;
    in_req = 1'b0; tcdm_gnt = '0; resp_en = '1; in_r_ready = 1'b1;
    n = 0;
    while (n < 40 && (exp_q.size() != 0 || resp_q[0].size() != 0 || resp_q[1].size() != 0 ||
                      resp_q[2].size() != 0 || resp_q[3].size() != 0)) begin
      cyc();
      n++;
    end
    chk(tag, 256'(exp_q.size()), 0);
  endtask

  initial begin
    logic [3:0] sk [7];
    int got;
    sk = '{4'h0, 4'h0, 4'h0, 4'h3, 4'h0, 4'h4, 4'h8};
    rst = 1'b1; in_req = 0; in_wen = 0; in_add = '0; in_be = '0; in_data = '0; in_id = '0;
    in_r_ready = 1'b1; tcdm_gnt = '0; resp_en = '0; tcdm_r_valid = '0; tcdm_r_data = '0;

    // Reset state
    settle();
    chk("rst_req", tcdm_req, 0);
    chk("rst_gnt", in_gnt, 0);
    chk("rst_rvld", in_r_valid, 0);
    chk("rst_rrdy", tcdm_r_ready, 4'hF);
    tick(); tick();
    rst = 1'b0;

    // All ports grant in the same cycle
    issue(1'b1, 32'h1000, 8'h1); tcdm_gnt = 4'hF;
    settle();
    chk("t1_req", tcdm_req, 4'hF);
    chk("t1_gnt", in_gnt, 1);
    chk("t1_add", tcdm_add, {32'h1060, 32'h1040, 32'h1020, 32'h1000});
    tick();
    drain("t1_drain");

    // Grant skew: port 0 first, ports 1-3 two cycles later
    hs_cnt = 0;
    issue(1'b1, 32'h2000, 8'h2); tcdm_gnt = 4'b0001;
    settle(); chk("t2_req0", tcdm_req, 4'hF); chk("t2_gnt0", in_gnt, 0); tick();
    tcdm_gnt = 4'b0000;
    settle(); chk("t2_req1", tcdm_req, 4'hE); chk("t2_gnt1", in_gnt, 0); tick();
    tcdm_gnt = 4'b1110;
    settle(); chk("t2_req2", tcdm_req, 4'hE); chk("t2_gnt2", in_gnt, 1); tick();
    chk("t2_hs", 256'(hs_cnt), 4);
    drain("t2_drain");

    // Response skew: ports return at cycles 3,3,5,6 -> wide valid at 7
    resp_en = '0;
    issue(1'b1, 32'h1000, 8'h5); tcdm_gnt = 4'hF;
    cyc();
    in_req = 1'b0; tcdm_gnt = '0;
    for (int c = 1; c < 7; c++) begin
      resp_en = sk[c];
      settle();
      if (c == 6) chk("t3_vld6", in_r_valid, 0);
      tick();
    end
    resp_en = '0;
    settle();
    chk("t3_vld7", in_r_valid, 1);
    chk("t3_id", in_r_id, 8'h5);
    chk("t3_bytes", {in_r_data[199:192], in_r_data[135:128], in_r_data[71:64], in_r_data[7:0]},
        32'hA3A2A1A0);
    tick();
    drain("t3_drain");

    // Credit limit with an interleaved write
    resp_en = '0; tcdm_gnt = 4'hF;
    issue(1'b1, 32'h3000, 8'h1); settle(); chk("t4_gntA", in_gnt, 1); tick();
    issue(1'b1, 32'h3100, 8'h2); settle(); chk("t4_gntB", in_gnt, 1); tick();
    issue(1'b0, 32'h4000, 8'h9); in_be = 32'hF0A5_3C01; in_data = {4{64'hDEAD_BEEF_0123_4567}};
    settle();
    chk("t4_wgnt", in_gnt, 1);
    chk("t4_wbe", tcdm_be, 32'hF0A5_3C01);
    chk("t4_wdata", tcdm_data, {4{64'hDEAD_BEEF_0123_4567}});
    tick();
    issue(1'b1, 32'h3200, 8'h3);
    for (int c = 0; c < 2; c++) begin
      settle(); chk("t4_stall_req", tcdm_req, 0); chk("t4_stall_gnt", in_gnt, 0); tick();
    end
    resp_en = '1; pop_cnt = 0; got = 0;
    for (int c = 0; c < 20 && got == 0; c++) begin
      settle();
      if (in_gnt) begin
        got = 1;
        chk("t4_pop_first", 256'(pop_cnt > 0), 1);
      end
      tick();
    end
    chk("t4_gntC", 256'(got), 1);
    drain("t4_drain");

    // Backpressure: two reads held while the consumer stalls
    in_r_ready = 1'b0; resp_en = '1; tcdm_gnt = 4'hF;
    issue(1'b1, 32'h5000, 8'h1); cyc();
    issue(1'b1, 32'h5200, 8'h2); cyc();
    in_req = 1'b0; tcdm_gnt = '0;
    for (int c = 0; c < 4; c++) cyc();
    settle();
    chk("t5_rrdy", tcdm_r_ready, 4'h0);
    chk("t5_vld", in_r_valid, 1);
    chk("t5_id", in_r_id, 8'h1);
    tick();
    drain("t5_drain");

    // Reset with two ports granted and one response buffered
    issue(1'b1, 32'h6000, 8'h7); tcdm_gnt = 4'b0011; resp_en = 4'b0001;
    cyc();
    tcdm_gnt = '0;
    cyc();
    rst = 1'b1; in_req = 1'b0; resp_en = '0;
    for (int p = 0; p < MP; p++) resp_q[p].delete();
    exp_q.delete();
    settle();
    chk("t6_req", tcdm_req, 0);
    chk("t6_gnt", in_gnt, 0);
    chk("t6_rvld", in_r_valid, 0);
    chk("t6_rrdy", tcdm_r_ready, 4'hF);
    tick();
    rst = 1'b0;
    issue(1'b1, 32'h6000, 8'h8); tcdm_gnt = '0;
    settle(); chk("t6_req_after", tcdm_req, 4'hF); tick();
    tcdm_gnt = 4'hF;
    settle(); chk("t6_gnt_after", in_gnt, 1); tick();
    drain("t6_drain");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
